// File: rtl/pin_entry_if.sv
// Keypad-side and controller-side signals of the PIN entry buffer.
// The buffer sits on the slave modport; the keypad/controller side uses master.
interface pin_entry_if #(
    parameter int MAX_DIGITS = 12
);
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    hold;
    logic [4*MAX_DIGITS-1:0] pin_digits;
    logic [3:0]              pin_len;
    logic                    pin_valid;
    logic                    entry_error;
    logic                    timeout;
    logic                    key_bip;
    logic [23:0]             disp_bcd;

    modport master (
        output key_valid, key_code, hold,
        input  pin_digits, pin_len, pin_valid, entry_error, timeout, key_bip, disp_bcd
    );

    modport slave (
        input  key_valid, key_code, hold,
        output pin_digits, pin_len, pin_valid, entry_error, timeout, key_bip, disp_bcd
    );
endinterface

// File: rtl/pin_entry_buffer.sv
// Collects keypad digits into a PIN, handles clear/enter/idle timeout and
// drives a right-aligned echo of the last six digits for the display.
module pin_entry_buffer #(
    parameter int MAX_DIGITS = 12,
    parameter int MIN_DIGITS = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    pin_entry_if.slave bus
);
    localparam int                BUF_W      = 4 * MAX_DIGITS;
    localparam int                TMR_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]        MAX_CNT    = 4'(MAX_DIGITS);
    localparam logic [3:0]        MIN_CNT    = 4'(MIN_DIGITS);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [23:0]       DISP_BLANK = 24'hFF_FFFF;

    logic             key_valid_q;
    logic [BUF_W-1:0] work_buf, nxt_buf;
    logic [3:0]       cnt, nxt_cnt;
    logic [TMR_W-1:0] tmr, nxt_tmr;
    logic [23:0]      disp_q, nxt_disp;
    logic [BUF_W-1:0] pin_q, nxt_pin;
    logic [3:0]       len_q, nxt_len;
    logic             valid_q, nxt_valid;
    logic             err_q, nxt_err;
    logic             tmo_q, nxt_tmo;
    logic             bip_q, nxt_bip;
    logic             press;
    logic             accept;
    logic             clear;

    assign press = bus.key_valid & ~key_valid_q;

    always_comb begin
        nxt_buf   = work_buf;
        nxt_cnt   = cnt;
        nxt_tmr   = tmr;
        nxt_disp  = disp_q;
        nxt_pin   = pin_q;
        nxt_len   = len_q;
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
        nxt_tmo   = 1'b0;
        nxt_bip   = 1'b0;
        accept    = 1'b0;
        clear     = 1'b0;

        // While hold is high, presses are swallowed and the idle timer is frozen.
        if (!bus.hold) begin
            if (press) begin
                if (bus.key_code <= 4'd9) begin
                    if (cnt < MAX_CNT) begin
                        for (int i = 0; i < MAX_DIGITS; i++) begin
                            if (cnt == 4'(i)) nxt_buf[4*i +: 4] = bus.key_code;
                        end
                        nxt_cnt  = cnt + 4'd1;
                        nxt_disp = {disp_q[19:0], bus.key_code};
                        accept   = 1'b1;
                    end
                end else if (bus.key_code == 4'hE) begin
                    accept = 1'b1;
                    clear  = 1'b1;
                end else if (bus.key_code == 4'hF) begin
                    accept = 1'b1;
                    clear  = 1'b1;
                    if (cnt >= MIN_CNT) begin
                        nxt_pin   = work_buf;
                        nxt_len   = cnt;
                        nxt_valid = 1'b1;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end

            // An accepted key in the expiry cycle wins and restarts the idle count.
            if (accept) begin
                nxt_bip = 1'b1;
                nxt_tmr = '0;
            end else if (cnt == 4'd0) begin
                nxt_tmr = '0;
            end else if (tmr == TMR_LAST) begin
                clear   = 1'b1;
                nxt_tmo = 1'b1;
                nxt_tmr = '0;
            end else begin
                nxt_tmr = tmr + TMR_W'(1);
            end
        end

        if (clear) begin
            nxt_buf  = '0;
            nxt_cnt  = 4'd0;
            nxt_disp = DISP_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_valid_q <= 1'b0;
            work_buf    <= '0;
            cnt         <= 4'd0;
            tmr         <= '0;
            disp_q      <= DISP_BLANK;
            pin_q       <= '0;
            len_q       <= 4'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            bip_q       <= 1'b0;
        end else begin
            key_valid_q <= bus.key_valid;
            work_buf    <= nxt_buf;
            cnt         <= nxt_cnt;
            tmr         <= nxt_tmr;
            disp_q      <= nxt_disp;
            pin_q       <= nxt_pin;
            len_q       <= nxt_len;
            valid_q     <= nxt_valid;
            err_q       <= nxt_err;
            tmo_q       <= nxt_tmo;
            bip_q       <= nxt_bip;
        end
    end

    assign bus.pin_digits  = pin_q;
    assign bus.pin_len     = len_q;
    assign bus.pin_valid   = valid_q;
    assign bus.entry_error = err_q;
    assign bus.timeout     = tmo_q;
    assign bus.key_bip     = bip_q;
    assign bus.disp_bcd    = disp_q;
endmodule
